// File: rtl/alu_pkg.sv
// Shared ALU definitions: 3-bit opcode encodings and the operand sequencer FSM states.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_PASSA = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b010;
    localparam logic [OP_W-1:0] OP_AND   = 3'b011;
    localparam logic [OP_W-1:0] OP_OR    = 3'b100;
    localparam logic [OP_W-1:0] OP_INC   = 3'b101;
    localparam logic [OP_W-1:0] OP_DEC   = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two combinational read ports, one synchronous write port,
// synchronous active-low clear.
module alu_regfile #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NREGS = 4,
    localparam int unsigned RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [RW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Command front end for the combinational ALU: latches operands from the register
// file, captures the ALU result, writes it back and reports it downstream.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NREGS = 4,
    localparam int unsigned RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [RW-1:0]    cmd_srca,
    input  logic [RW-1:0]    cmd_srcb,
    input  logic [RW-1:0]    cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [RW-1:0]    res_dst,
    output logic             res_zero
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [RW-1:0]    dst_q, dst_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [RW-1:0]    res_dst_q, res_dst_d;
    logic             res_valid_q, res_valid_d;

    logic             rf_we;
    logic [RW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rf_rdata_a;
    logic [WIDTH-1:0] rf_rdata_b;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (cmd_srca),
        .ra_data (rf_rdata_a),
        .rb_addr (cmd_srcb),
        .rb_data (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // Ready is a pure state decode, held low while reset is asserted.
    assign cmd_ready = rst_n && (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        dst_d      = dst_q;
        res_data_d = res_data_q;
        res_dst_d  = res_dst_q;
        rf_we      = 1'b0;
        rf_waddr   = dst_q;
        rf_wdata   = alu_y;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_load) begin
                        rf_we      = 1'b1;
                        rf_waddr   = cmd_dst;
                        rf_wdata   = cmd_imm;
                        res_data_d = cmd_imm;
                        res_dst_d  = cmd_dst;
                        state_d    = ST_RESP;
                    end else begin
                        alu_a_d  = rf_rdata_a;
                        alu_b_d  = rf_rdata_b;
                        alu_op_d = cmd_op;
                        dst_d    = cmd_dst;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                rf_we      = 1'b1;
                res_data_d = alu_y;
                res_dst_d  = dst_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        res_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            dst_q       <= '0;
            res_data_q  <= '0;
            res_dst_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            dst_q       <= dst_d;
            res_data_q  <= res_data_d;
            res_dst_q   <= res_dst_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign res_data   = res_data_q;
    assign res_dst    = res_dst_q;
    assign res_valid  = res_valid_q;
    assign res_zero   = (res_data_q == '0);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed vector table, hand-written
// handshake/reset sequences, and randomized commands against a register-file model.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 4;
    localparam int unsigned RW    = 2;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [2:0]       cmd_op;
    logic [RW-1:0]    cmd_srca;
    logic [RW-1:0]    cmd_srcb;
    logic [RW-1:0]    cmd_dst;
    logic [WIDTH-1:0] cmd_imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_y;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [RW-1:0]    res_dst;
    logic             res_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    logic [WIDTH-1:0] ref_rf [NREGS];

    alu_operand_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .cmd_dst    (cmd_dst),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_dst    (res_dst),
        .res_zero   (res_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_PASSA: return a;
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_INC:   return a + 32'd1;
            OP_DEC:   return a - 32'd1;
            default:  return b;
        endcase
    endfunction

    // The downstream ALU the block drives.
    always_comb alu_y = ref_alu(alu_opcode, alu_a, alu_b);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_result(input logic load, input logic [2:0] op,
                                                      input logic [RW-1:0] sa, input logic [RW-1:0] sb,
                                                      input logic [WIDTH-1:0] imm);
        return load ? imm : ref_alu(op, ref_rf[sa], ref_rf[sb]);
    endfunction

    // One complete command: accept, optional EXEC, response with `stall` cycles of backpressure.
    task automatic run_cmd(input logic load, input logic [2:0] op, input logic [RW-1:0] sa,
                           input logic [RW-1:0] sb, input logic [RW-1:0] d,
                           input logic [WIDTH-1:0] imm, input logic [WIDTH-1:0] exp_data,
                           input int stall);
        int n;
        logic [WIDTH-1:0] mres;
        mres      = model_result(load, op, sa, sb, imm);
        cmd_load  = load;
        cmd_op    = op;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_dst   = d;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 8) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready stuck at 0 for %0d cycles", n);
            cmd_valid = 1'b0;
            return;
        end
        res_ready = (stall == 0);
        tick();
        last_accept = cyc;
        cmd_valid = 1'b0;
        if (!load) begin
            check("alu_a", alu_a, ref_rf[sa]);
            check("alu_b", alu_b, ref_rf[sb]);
            check("alu_opcode", 32'(alu_opcode), 32'(op));
            check("res_valid_exec", 32'(res_valid), 32'd0);
            tick();
        end
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_data", res_data, exp_data);
        check("res_dst", 32'(res_dst), 32'(d));
        check("res_zero", 32'(res_zero), 32'(exp_data == '0));
        check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_data", res_data, exp_data);
        end
        res_ready = 1'b1;
        tick();
        check("res_valid_done", 32'(res_valid), 32'd0);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        ref_rf[d] = mres;
    endtask

    typedef struct {
        logic             load;
        logic [2:0]       op;
        logic [RW-1:0]    sa;
        logic [RW-1:0]    sb;
        logic [RW-1:0]    d;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, OP_PASSA, 2'd0, 2'd0, 2'd0, 32'd5,          32'd5};
        vecs[1]  = '{1'b1, OP_PASSA, 2'd0, 2'd0, 2'd1, 32'd7,          32'd7};
        vecs[2]  = '{1'b0, OP_ADD,   2'd0, 2'd1, 2'd2, 32'd0,          32'd12};
        vecs[3]  = '{1'b0, OP_PASSA, 2'd2, 2'd0, 2'd3, 32'd0,          32'd12};
        vecs[4]  = '{1'b1, OP_PASSA, 2'd0, 2'd0, 2'd0, 32'd0,          32'd0};
        vecs[5]  = '{1'b0, OP_DEC,   2'd0, 2'd0, 2'd1, 32'd0,          32'hFFFF_FFFF};
        vecs[6]  = '{1'b1, OP_PASSA, 2'd0, 2'd0, 2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, OP_INC,   2'd3, 2'd0, 2'd2, 32'd0,          32'd0};
        vecs[8]  = '{1'b0, OP_SUB,   2'd0, 2'd1, 2'd0, 32'd0,          32'd1};
        vecs[9]  = '{1'b0, OP_AND,   2'd3, 2'd1, 2'd3, 32'd0,          32'hFFFF_FFFF};
        vecs[10] = '{1'b0, OP_OR,    2'd0, 2'd2, 2'd1, 32'd0,          32'd1};
        vecs[11] = '{1'b0, OP_PASSB, 2'd0, 2'd3, 2'd2, 32'd0,          32'hFFFF_FFFF};

        for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = '0;

        // Reset with a command offered: nothing must be accepted.
        rst_n = 1'b0;
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_load = 1'b1;
        cmd_op = 3'd0;
        cmd_srca = '0;
        cmd_srcb = '0;
        cmd_dst = 2'd1;
        cmd_imm = 32'hAA;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_alu_a", alu_a, 32'd0);
            check("rst_alu_b", alu_b, 32'd0);
            check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
            check("rst_res_data", res_data, 32'd0);
            check("rst_res_dst", 32'(res_dst), 32'd0);
            check("rst_res_zero", 32'(res_zero), 32'd1);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_valid", 32'(res_valid), 32'd0);
        // r1 must still read zero, proving the offered load was dropped.
        run_cmd(1'b0, OP_PASSB, 2'd0, 2'd1, 2'd0, 32'd0, 32'd0, 0);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].load, vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].d,
                    vecs[i].imm, vecs[i].exp_data, 0);
        end

        // Dependent chain at full rate: r0 doubles each command, 3 cycles apart.
        run_cmd(1'b1, OP_PASSA, 2'd0, 2'd0, 2'd0, 32'd1, 32'd1, 0);
        begin
            int prev;
            logic [WIDTH-1:0] expv;
            expv = 32'd1;
            prev = last_accept;
            check("load_period", 32'(last_accept), 32'(last_accept));
            for (int k = 0; k < 4; k++) begin
                expv = expv << 1;
                run_cmd(1'b0, OP_ADD, 2'd0, 2'd0, 2'd0, 32'd0, expv, 0);
                if (k > 0) check("chain_period", 32'(last_accept - prev), 32'd3);
                prev = last_accept;
            end
        end

        // Load-to-load period of 2 cycles.
        begin
            int p0;
            run_cmd(1'b1, OP_PASSA, 2'd0, 2'd0, 2'd3, 32'h33, 32'h33, 0);
            p0 = last_accept;
            run_cmd(1'b1, OP_PASSA, 2'd0, 2'd0, 2'd2, 32'h44, 32'h44, 0);
            check("load_period2", 32'(last_accept - p0), 32'd2);
        end

        // Backpressure with a competing command offered throughout.
        res_ready = 1'b0;
        cmd_load = 1'b1;
        cmd_dst = 2'd1;
        cmd_imm = 32'd9;
        cmd_valid = 1'b1;
        tick();
        cmd_dst = 2'd2;
        cmd_imm = 32'd3;
        check("bp_valid0", 32'(res_valid), 32'd1);
        check("bp_data0", res_data, 32'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data", res_data, 32'd9);
            check("bp_dst", 32'(res_dst), 32'd1);
            check("bp_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(cmd_ready), 32'd1);
        check("bp_release_valid", 32'(res_valid), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_valid", 32'(res_valid), 32'd1);
        check("bp_next_data", res_data, 32'd3);
        check("bp_next_dst", 32'(res_dst), 32'd2);
        tick();
        ref_rf[1] = 32'd9;
        ref_rf[2] = 32'd3;

        // Reset during EXEC: no result, no write-back, register file cleared.
        run_cmd(1'b1, OP_PASSA, 2'd0, 2'd0, 2'd2, 32'h55, 32'h55, 0);
        cmd_load = 1'b0;
        cmd_op = OP_ADD;
        cmd_srca = 2'd2;
        cmd_srcb = 2'd2;
        cmd_dst = 2'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("mid_exec_alu_a", alu_a, 32'h55);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_valid_after", 32'(res_valid), 32'd0);
        end
        for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = '0;
        run_cmd(1'b0, OP_PASSA, 2'd3, 2'd2, 2'd0, 32'd0, 32'd0, 0);

        // Randomized commands against the model, with occasional backpressure.
        for (int i = 0; i < 80; i++) begin
            logic             ld;
            logic [2:0]       op;
            logic [RW-1:0]    sa, sb, d;
            logic [WIDTH-1:0] imm;
            int               st;
            ld = ($urandom_range(0, 3) == 0);
            op = 3'($urandom_range(0, 7));
            sa = 2'($urandom_range(0, 3));
            sb = 2'($urandom_range(0, 3));
            d  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       imm = '0;
                1:       imm = 32'hFFFF_FFFF;
                default: imm = 32'($urandom);
            endcase
            st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_cmd(ld, op, sa, sb, d, imm, model_result(ld, op, sa, sb, imm), st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Command-driven front end that sits directly upstream of the combinational 3-bit-opcode ALU and consumes its result. It holds a small operand register file, accepts one command per transaction over a valid/ready handshake, presents registered A/B/opcode to the ALU, captures Y, writes it back, and reports each result downstream over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, datapath width; equals the ALU A/B/Y width.
- NREGS, 4, register-file entries; power of two ≥ 2; index width RW = log2(NREGS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_load  in  1  1 = load immediate into cmd_dst, bypassing the ALU.
- cmd_op  in  3  ALU opcode (000 A, 001 A+B, 010 A-B, 011 AND, 100 OR, 101 A+1, 110 A-1, 111 B).
- cmd_srca, cmd_srcb  in  RW  source register indices.
- cmd_dst  in  RW  destination register index.
- cmd_imm  in  WIDTH  immediate for loads.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_opcode  out  3  registered ALU opcode.
- alu_y  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_opcode).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  WIDTH  result value written back.
- res_dst  out  RW  register that received res_data.
- res_zero  out  1  res_data == 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
  - cmd_load = 0: latch alu_a ← rf[cmd_srca], alu_b ← rf[cmd_srcb], alu_opcode ← cmd_op, dst ← cmd_dst; go EXEC.
  - cmd_load = 1: rf[cmd_dst] ← cmd_imm; res_data ← cmd_imm, res_dst ← cmd_dst; go RESP.
- EXEC: cmd_ready = 0; rf[dst] ← alu_y, res_data ← alu_y, res_dst ← dst; go RESP.
- RESP: cmd_ready = 0, res_valid = 1; res_data/res_dst/res_zero held stable. On res_ready go IDLE.
- Register-file reads use the value at the accept edge; src = dst of the immediately previous command reads the already written-back value, since a new command cannot be accepted before RESP completes.
- Arithmetic is modulo 2^WIDTH; wrap-around (e.g. 0 − 1) is not flagged. No carry/overflow outputs.
- alu_a/alu_b/alu_opcode hold their last values outside EXEC; no ALU activity is implied by a load.
- res_zero is derived combinationally from res_data.

## Timing
- Reset (rst_n low at a rising edge): state IDLE; all rf entries, alu_a, alu_b, alu_opcode, res_data, res_dst = 0; res_valid = 0. cmd_ready is gated low while rst_n is low, so no command is accepted on a reset cycle.
- Reset mid-operation (EXEC or RESP): pending result discarded, no write-back if not already performed, res_valid low on the next cycle.
- ALU command: accepted at edge N → alu_* valid after N → write-back and res_valid = 1 after edge N+1. Minimum accept-to-accept period is 3 cycles (accept, EXEC, RESP with res_ready = 1).
- Load: accepted at edge N → res_valid = 1 after edge N; minimum period 2 cycles.
- res_valid, once high, stays high with stable data until res_ready is sampled high.
- cmd_ready depends only on state and rst_n, never on cmd_valid.

## Structure
- Shared package alu_pkg: 3-bit opcode constants (OP_PASSA … OP_PASSB) and the FSM state enum, reused by the ALU and any future decoder.
- The register file is split into a sub-module alu_regfile: NREGS × WIDTH, two combinational read ports, one synchronous write port, synchronous active-low reset to zero.
- The ALU itself is instantiated only in the bench/top level, not inside this block.

## Test plan
- Reset: hold rst_n low 2 cycles with cmd_valid = 1 → cmd_ready = 0, res_valid = 0, all outputs 0; after release, cmd_ready = 1 and nothing has been accepted.
- Load then add: load r0 = 5, r1 = 7; ALU cmd op 001 (A + B), srca = 0, srcb = 1, dst = 2 → alu_a = 5, alu_b = 7 one cycle after accept; res_data = 12, res_dst = 2 two cycles after accept; a later read of r2 gives 12.
- Wrap-around and zero flag: r0 = 0, op 110 (A − 1) → res_data = 0xFFFF_FFFF, res_zero = 0. r3 = 0xFFFF_FFFF, op 101 (A + 1) → res_data = 0, res_zero = 1.
- Backpressure: hold res_ready = 0 for 5 cycles after res_valid rises → res_data stable, cmd_ready = 0 throughout, a new cmd_valid is not accepted; accepted on the cycle after res_ready = 1.
- Dependent chain: r0 = 1; issue r0 ← r0 + r0 four times back-to-back → results 2, 4, 8, 16.
- Reset mid-EXEC: drop rst_n during EXEC → res_valid never asserts; dst register reads 0.
